ldl_round_req: RTL and testbench

// - Requester-side companion of the priority round-robin arbiter: holds one pending request per port,

---
 rtl/ldl_round_pkg.sv | 28 ++
 rtl/ldl_round_age_cell.sv | 59 +++++
 rtl/ldl_round_req.sv | 99 +++++++++
 tb/tb_ldl_round_req.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ldl_round_pkg.sv
// rtl/ldl_round_pkg.sv - shared types and helpers for the round-robin requester
package ldl_round_pkg;

    localparam int LDL_BIN_WIDTH = 3;
    localparam int LDL_COS_WIDTH = 2;
    localparam int LDL_REQ_WIDTH = 1 << LDL_BIN_WIDTH;
    localparam int LDL_AGE_WIDTH = 4;

    typedef logic [LDL_COS_WIDTH-1:0] cos_t;
    typedef logic [LDL_AGE_WIDTH-1:0] age_t;
    typedef logic [LDL_BIN_WIDTH-1:0] bin_t;

    function automatic bin_t onehot2bin(input logic [LDL_REQ_WIDTH-1:0] hot);
        bin_t b;
        b = '0;
        for (int i = 0; i < LDL_REQ_WIDTH; i++) begin
            if (hot[i]) begin
                b = b | bin_t'(i);
            end
        end
        return b;
    endfunction

    function automatic cos_t cos_inc_sat(input cos_t c);
        return (c == '1) ? c : c + cos_t'(1);
    endfunction

endpackage

// File: rtl/ldl_round_age_cell.sv
// rtl/ldl_round_age_cell.sv - one port's pending slot with starvation aging
module ldl_round_age_cell
    import ldl_round_pkg::*;
#(
    parameter int AGE_WIDTH = 4,
    parameter int AGE_LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_accept,
    input  logic i_take,
    input  cos_t i_cos,
    output logic o_pend,
    output cos_t o_base_cos,
    output cos_t o_eff_cos,
    output logic o_aged
);

    logic                 r_pend;
    cos_t                 r_base_cos;
    cos_t                 r_eff_cos;
    logic [AGE_WIDTH-1:0] r_age;
    logic                 r_aged;

    // accept has priority over take so a reissue on the granting cycle reloads the slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= 1'b0;
            r_base_cos <= '0;
            r_eff_cos  <= '0;
            r_age      <= '0;
            r_aged     <= 1'b0;
        end else if (i_accept) begin
            r_pend     <= 1'b1;
            r_base_cos <= i_cos;
            r_eff_cos  <= i_cos;
            r_age      <= '0;
            r_aged     <= 1'b0;
        end else if (i_take) begin
            r_pend <= 1'b0;
            r_age  <= '0;
            r_aged <= 1'b0;
        end else if (r_pend) begin
            if (r_age == AGE_WIDTH'(AGE_LIMIT - 1)) begin
                r_age     <= '0;
                r_eff_cos <= cos_inc_sat(r_eff_cos);
                r_aged    <= 1'b1;
            end else begin
                r_age <= r_age + AGE_WIDTH'(1);
            end
        end
    end

    assign o_pend     = r_pend;
    assign o_base_cos = r_base_cos;
    assign o_eff_cos  = r_eff_cos;
    assign o_aged     = r_aged;

endmodule

// File: rtl/ldl_round_req.sv
// rtl/ldl_round_req.sv - requester front end for the priority round-robin arbiter
module ldl_round_req
    import ldl_round_pkg::*;
#(
    parameter int BIN_WIDTH = LDL_BIN_WIDTH,
    parameter int COS_WIDTH = LDL_COS_WIDTH,
    parameter int REQ_WIDTH = 1 << BIN_WIDTH,
    parameter int AGE_WIDTH = LDL_AGE_WIDTH,
    parameter int AGE_LIMIT = 15
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [REQ_WIDTH-1:0]           in_vld,
    input  logic [REQ_WIDTH*COS_WIDTH-1:0] in_cos,
    output logic [REQ_WIDTH-1:0]           in_rdy,
    output logic [REQ_WIDTH-1:0]           arb_req,
    output logic [REQ_WIDTH*COS_WIDTH-1:0] arb_cos,
    input  logic                           arb_ack,
    input  logic [REQ_WIDTH-1:0]           arb_hot,
    output logic                           gnt_vld,
    output logic [BIN_WIDTH-1:0]           gnt_bin,
    output logic [COS_WIDTH-1:0]           gnt_cos,
    output logic                           gnt_aged,
    output logic                           err
);

    logic [REQ_WIDTH-1:0] w_pend;
    logic [REQ_WIDTH-1:0] w_aged;
    logic [REQ_WIDTH-1:0] w_take;
    logic [REQ_WIDTH-1:0] w_accept;
    cos_t                 w_base_cos [REQ_WIDTH];
    logic                 w_hot_onehot;
    logic                 w_hot_pending;
    logic                 w_ack_ok;
    logic                 w_ack_bad;
    bin_t                 w_bin;

    logic                 r_gnt_vld;
    bin_t                 r_gnt_bin;
    cos_t                 r_gnt_cos;
    logic                 r_gnt_aged;
    logic                 r_err;

    // a grant is only honoured when it names exactly one port that actually holds a request
    assign w_hot_onehot  = (arb_hot != '0) && ((arb_hot & (arb_hot - REQ_WIDTH'(1))) == '0);
    assign w_hot_pending = (arb_hot & ~w_pend) == '0;
    assign w_ack_ok      = arb_ack & w_hot_onehot & w_hot_pending;
    assign w_ack_bad     = arb_ack & ~(w_hot_onehot & w_hot_pending);
    assign w_take        = w_ack_ok ? arb_hot : '0;
    assign w_bin         = onehot2bin(arb_hot);

    assign in_rdy   = ~w_pend | w_take;
    assign w_accept = in_vld & in_rdy;
    assign arb_req  = w_pend;

    for (genvar g = 0; g < REQ_WIDTH; g++) begin : g_cell
        ldl_round_age_cell #(
            .AGE_WIDTH (AGE_WIDTH),
            .AGE_LIMIT (AGE_LIMIT)
        ) u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_accept   (w_accept[g]),
            .i_take     (w_take[g]),
            .i_cos      (in_cos[g*COS_WIDTH +: COS_WIDTH]),
            .o_pend     (w_pend[g]),
            .o_base_cos (w_base_cos[g]),
            .o_eff_cos  (arb_cos[g*COS_WIDTH +: COS_WIDTH]),
            .o_aged     (w_aged[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_vld  <= 1'b0;
            r_gnt_bin  <= '0;
            r_gnt_cos  <= '0;
            r_gnt_aged <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_gnt_vld <= w_ack_ok;
            if (w_ack_ok) begin
                r_gnt_bin  <= w_bin;
                r_gnt_cos  <= w_base_cos[w_bin];
                r_gnt_aged <= w_aged[w_bin];
            end
            if (w_ack_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign gnt_vld  = r_gnt_vld;
    assign gnt_bin  = r_gnt_bin;
    assign gnt_cos  = r_gnt_cos;
    assign gnt_aged = r_gnt_aged;
    assign err      = r_err;

endmodule

// File: tb/tb_ldl_round_req.sv
// tb/tb_ldl_round_req.sv - directed vector bench for ldl_round_req
module tb_ldl_round_req;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_vld;
    logic [15:0] in_cos;
    logic [7:0]  in_rdy;
    logic [7:0]  arb_req;
    logic [15:0] arb_cos;
    logic        arb_ack;
    logic [7:0]  arb_hot;
    logic        gnt_vld;
    logic [2:0]  gnt_bin;
    logic [1:0]  gnt_cos;
    logic        gnt_aged;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    ldl_round_req #(
        .BIN_WIDTH (3),
        .COS_WIDTH (2),
        .REQ_WIDTH (8),
        .AGE_WIDTH (4),
        .AGE_LIMIT (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_cos   (in_cos),
        .in_rdy   (in_rdy),
        .arb_req  (arb_req),
        .arb_cos  (arb_cos),
        .arb_ack  (arb_ack),
        .arb_hot  (arb_hot),
        .gnt_vld  (gnt_vld),
        .gnt_bin  (gnt_bin),
        .gnt_cos  (gnt_cos),
        .gnt_aged (gnt_aged),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  vld;
        logic [15:0] cos;
        logic        ack;
        logic [7:0]  hot;
        logic [7:0]  e_rdy;
        logic [7:0]  e_req;
        logic        e_gv;
        logic [2:0]  e_gbin;
        logic [1:0]  e_gcos;
        logic        e_gaged;
        logic        e_err;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] v, input logic [15:0] c, input logic a, input logic [7:0] h);
        in_vld  = v;
        in_cos  = c;
        arb_ack = a;
        arb_hot = h;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(8'h00, 16'h0000, 1'b0, 8'h00);

        //       vld    cos       ack  hot    rdy    req    gv  gbin  gcos gaged err
        vt[0]  = '{8'h00, 16'h0000, 1'b0, 8'h00, 8'hff, 8'h00, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0};
        vt[1]  = '{8'h20, 16'h0800, 1'b0, 8'h00, 8'hff, 8'h20, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0};
        vt[2]  = '{8'h00, 16'h0000, 1'b1, 8'h20, 8'hff, 8'h00, 1'b1, 3'd5, 2'd2, 1'b0, 1'b0};
        vt[3]  = '{8'h00, 16'h0000, 1'b0, 8'h00, 8'hff, 8'h00, 1'b0, 3'd5, 2'd2, 1'b0, 1'b0};
        vt[4]  = '{8'h04, 16'h0010, 1'b0, 8'h00, 8'hff, 8'h04, 1'b0, 3'd5, 2'd2, 1'b0, 1'b0};
        vt[5]  = '{8'h04, 16'h0030, 1'b1, 8'h04, 8'hff, 8'h04, 1'b1, 3'd2, 2'd1, 1'b0, 1'b0};
        vt[6]  = '{8'h00, 16'h0000, 1'b1, 8'h04, 8'hff, 8'h00, 1'b1, 3'd2, 2'd3, 1'b0, 1'b0};
        vt[7]  = '{8'h00, 16'h0000, 1'b0, 8'h00, 8'hff, 8'h00, 1'b0, 3'd2, 2'd3, 1'b0, 1'b0};
        vt[8]  = '{8'h03, 16'h0000, 1'b0, 8'h00, 8'hff, 8'h03, 1'b0, 3'd2, 2'd3, 1'b0, 1'b0};
        vt[9]  = '{8'h00, 16'h0000, 1'b1, 8'h03, 8'hfc, 8'h03, 1'b0, 3'd2, 2'd3, 1'b0, 1'b1};
        vt[10] = '{8'h00, 16'h0000, 1'b1, 8'h80, 8'hfc, 8'h03, 1'b0, 3'd2, 2'd3, 1'b0, 1'b1};
        vt[11] = '{8'h00, 16'h0000, 1'b1, 8'h00, 8'hfc, 8'h03, 1'b0, 3'd2, 2'd3, 1'b0, 1'b1};
        vt[12] = '{8'h00, 16'h0000, 1'b1, 8'h01, 8'hfd, 8'h02, 1'b1, 3'd0, 2'd0, 1'b0, 1'b1};
        vt[13] = '{8'h00, 16'h0000, 1'b1, 8'h02, 8'hff, 8'h00, 1'b1, 3'd1, 2'd0, 1'b1, 1'b1};
        vt[14] = '{8'h00, 16'h0000, 1'b0, 8'h00, 8'hff, 8'h00, 1'b0, 3'd1, 2'd0, 1'b1, 1'b1};

        step();
        step();
        chk("reset_arb_req", 32'(arb_req), 32'h00);
        chk("reset_in_rdy", 32'(in_rdy), 32'hff);
        chk("reset_arb_cos", 32'(arb_cos), 32'h0000);
        chk("reset_gnt_vld", 32'(gnt_vld), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(vt[i].vld, vt[i].cos, vt[i].ack, vt[i].hot);
            #1;
            chk($sformatf("v%0d_in_rdy", i), 32'(in_rdy), 32'(vt[i].e_rdy));
            step();
            chk($sformatf("v%0d_arb_req", i), 32'(arb_req), 32'(vt[i].e_req));
            chk($sformatf("v%0d_gnt_vld", i), 32'(gnt_vld), 32'(vt[i].e_gv));
            chk($sformatf("v%0d_gnt_bin", i), 32'(gnt_bin), 32'(vt[i].e_gbin));
            chk($sformatf("v%0d_gnt_cos", i), 32'(gnt_cos), 32'(vt[i].e_gcos));
            chk($sformatf("v%0d_gnt_aged", i), 32'(gnt_aged), 32'(vt[i].e_gaged));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vt[i].e_err));
        end

        // mid-traffic reset with three requests pending
        drive(8'h0e, 16'h00a4, 1'b0, 8'h00);
        step();
        drive(8'h00, 16'h0000, 1'b0, 8'h00);
        chk("pre_reset_req", 32'(arb_req), 32'h0e);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_arb_req", 32'(arb_req), 32'h00);
        chk("mid_reset_in_rdy", 32'(in_rdy), 32'hff);
        chk("mid_reset_gnt_vld", 32'(gnt_vld), 32'd0);
        chk("mid_reset_err", 32'(err), 32'd0);
        step();
        chk("reset_edge_arb_req", 32'(arb_req), 32'h00);
        rst_n = 1'b1;
        step();
        chk("post_reset_gnt_vld", 32'(gnt_vld), 32'd0);

        // aging: port 0 cos0 starved by port 7 cos3 reissued every cycle
        drive(8'h81, 16'hc000, 1'b0, 8'h00);
        step();
        for (int w = 1; w <= 12; w++) begin
            drive(8'h80, 16'hc000, 1'b1, 8'h80);
            step();
            if (w == 4)  chk("age_w4_eff_cos", 32'(arb_cos[1:0]), 32'd1);
            if (w == 8)  chk("age_w8_eff_cos", 32'(arb_cos[1:0]), 32'd2);
            if (w == 12) chk("age_w12_eff_cos", 32'(arb_cos[1:0]), 32'd3);
        end
        chk("age_port7_report", 32'({gnt_vld, gnt_bin, gnt_cos}), 32'({1'b1, 3'd7, 2'd3}));
        drive(8'h00, 16'h0000, 1'b1, 8'h01);
        step();
        chk("age_gnt_vld", 32'(gnt_vld), 32'd1);
        chk("age_gnt_bin", 32'(gnt_bin), 32'd0);
        chk("age_gnt_cos", 32'(gnt_cos), 32'd0);
        chk("age_gnt_aged", 32'(gnt_aged), 32'd1);
        chk("age_arb_req", 32'(arb_req), 32'h80);

        // saturation: port 3 at cos3 waits 3*AGE_LIMIT cycles
        drive(8'h08, 16'h00c0, 1'b0, 8'h00);
        step();
        drive(8'h00, 16'h0000, 1'b0, 8'h00);
        for (int w = 1; w <= 12; w++) begin
            step();
            if (w % 4 == 0) chk($sformatf("sat_w%0d_eff_cos", w), 32'(arb_cos[7:6]), 32'd3);
        end
        drive(8'h00, 16'h0000, 1'b1, 8'h08);
        step();
        chk("sat_gnt", 32'({gnt_vld, gnt_bin, gnt_cos, gnt_aged}), 32'({1'b1, 3'd3, 2'd3, 1'b1}));
        drive(8'h00, 16'h0000, 1'b0, 8'h00);
        step();
        chk("sat_gnt_pulse_end", 32'(gnt_vld), 32'd0);
        chk("sat_err_clear", 32'(err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
